muldiv_sched: RTL

Sequencing controller for the multiply/divide resource of the MIPS execute stage. It owns the architectural HI/LO registers, accepts one-hot mult/div/move ops from EX, and runs a two-cycle multiply and a 32-iteration restoring divider. It raises `stall` to hold EX until a result is ready. It commits HI/LO only when the op retires, and discards in-flight work on `flush`.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_sched_div_core.sv | 68 ++++++
 rtl/muldiv_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide early-out).
package muldiv_pkg;

   // One-hot op bit positions
   localparam int unsigned OP_MULT  = 0;
   localparam int unsigned OP_MULTU = 1;
   localparam int unsigned OP_DIV   = 2;
   localparam int unsigned OP_DIVU  = 3;
   localparam int unsigned OP_MTHI  = 4;
   localparam int unsigned OP_MTLO  = 5;
   localparam int unsigned OP_MFHI  = 6;
   localparam int unsigned OP_MFLO  = 7;

   // MIPS32 divider iteration count
   localparam int unsigned DIV_ITERS = 32;

   // Divide-by-zero: LO is all ones, HI returns the dividend unchanged
   localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV_BUSY,
      ST_DIV_DONE
   } state_t;

   // Magnitude of a 32-bit operand; 0x80000000 stays 0x80000000 as unsigned
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_sched_div_core.sv
// Unsigned restoring divider datapath, one quotient bit per cycle.
// Optional feature macro: MULDIV_EARLY_OUT_EN (driven through the skip input).
module div_core #(
   parameter int unsigned ITERS = 32
)(
   input  logic        clk,
   input  logic        cancel,
   input  logic        start,
   input  logic        skip,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic [31:0]   rem_q;
   logic [31:0]   quo_q;
   logic [31:0]   dvs_q;
   logic [CW-1:0] cnt_q;
   logic          run_q;

   logic [32:0]   trial;
   logic          fits;

   // Trial subtraction of the divisor from the shifted partial remainder
   always_comb begin
      trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
      fits  = ~trial[32];
   end

   // Load on start, then shift/subtract once per cycle until the count expires
   always_ff @(posedge clk) begin
      if (cancel) begin
         run_q <= 1'b0;
      end else if (start) begin
         dvs_q <= divisor;
         cnt_q <= CW'(ITERS - 1);
         if (skip) begin
            quo_q <= '0;
            rem_q <= dividend;
            run_q <= 1'b0;
         end else begin
            quo_q <= dividend;
            rem_q <= '0;
            run_q <= 1'b1;
         end
      end else if (run_q) begin
         if (fits) begin
            rem_q <= trial[31:0];
         end else begin
            rem_q <= {rem_q[30:0], quo_q[31]};
         end
         quo_q <= {quo_q[30:0], fits};
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == '0) begin
            run_q <= 1'b0;
         end
      end
   end

   assign done      = run_q && (cnt_q == '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sched.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, stalls EX while
// a mult/div is in flight, commits only on retirement, drops work on flush.
// Optional feature macro: MULDIV_EARLY_OUT_EN (skip divide when |a| < |b|).
module muldiv_sched #(
   parameter int unsigned DIV_ITERS = muldiv_pkg::DIV_ITERS
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [7:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   import muldiv_pkg::*;

   state_t      state_q, state_d;
   logic [31:0] hi_q, lo_q;

   logic        is_mul, is_div, sgn_op;
   logic [31:0] mag_a, mag_b;
   logic        early_ok;
   logic        acc_mul, acc_div, skip_div;

   // Multiply operand stage
   logic [31:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
   logic        mul_neg_q;
   logic [63:0] prod_mag, prod;

   // Divide sign/zero bookkeeping
   logic        q_neg_q, r_neg_q, div_zero_q;
   logic [31:0] div_a_raw_q;
   logic        div_done;
   logic [31:0] div_quo, div_rem;
   logic [31:0] quo_s, rem_s;

   // Operand decode and magnitudes for the accept cycle
   always_comb begin
      is_mul = op[OP_MULT] | op[OP_MULTU];
      is_div = op[OP_DIV]  | op[OP_DIVU];
      sgn_op = op[OP_MULT] | op[OP_DIV];
      mag_a  = mag32(src1, sgn_op);
      mag_b  = mag32(src2, sgn_op);
`ifdef MULDIV_EARLY_OUT_EN
      early_ok = (src2 != '0) && (mag_a < mag_b);
`else
      early_ok = 1'b0;
`endif
   end

   // Next-state and stall decode; flush forces IDLE from any state
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      acc_mul  = 1'b0;
      acc_div  = 1'b0;
      skip_div = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_valid && !flush && !reset) begin
               if (is_mul) begin
                  stall   = 1'b1;
                  acc_mul = 1'b1;
                  state_d = ST_MUL;
               end else if (is_div) begin
                  stall   = 1'b1;
                  acc_div = 1'b1;
                  if (early_ok) begin
                     skip_div = 1'b1;
                     state_d  = ST_DIV_DONE;
                  end else begin
                     state_d  = ST_DIV_BUSY;
                  end
               end
            end
         end
         ST_MUL: begin
            state_d = ST_IDLE;
         end
         ST_DIV_BUSY: begin
            stall = 1'b1;
            if (div_done) begin
               state_d = ST_DIV_DONE;
            end
         end
         ST_DIV_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture partial products and sign flags on accept
   always_ff @(posedge clk) begin
      if (acc_mul) begin
         pp_ll_q   <= 32'(mag_a[15:0])  * 32'(mag_b[15:0]);
         pp_lh_q   <= 32'(mag_a[15:0])  * 32'(mag_b[31:16]);
         pp_hl_q   <= 32'(mag_a[31:16]) * 32'(mag_b[15:0]);
         pp_hh_q   <= 32'(mag_a[31:16]) * 32'(mag_b[31:16]);
         mul_neg_q <= op[OP_MULT] & (src1[31] ^ src2[31]);
      end
      if (acc_div) begin
         q_neg_q     <= op[OP_DIV] & (src1[31] ^ src2[31]);
         r_neg_q     <= op[OP_DIV] & src1[31];
         div_zero_q  <= (src2 == '0);
         div_a_raw_q <= src1;
      end
   end

   div_core #(
      .ITERS (DIV_ITERS)
   ) u_div_core (
      .clk       (clk),
      .cancel    (flush | reset),
      .start     (acc_div),
      .skip      (skip_div),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Product assembly and divide sign correction for the retire cycle
   always_comb begin
      prod_mag = 64'(pp_ll_q)
               + {16'b0, pp_lh_q, 16'b0}
               + {16'b0, pp_hl_q, 16'b0}
               + {pp_hh_q, 32'b0};
      prod     = mul_neg_q ? (~prod_mag + 64'd1) : prod_mag;
      quo_s    = q_neg_q ? (~div_quo + 32'd1) : div_quo;
      rem_s    = r_neg_q ? (~div_rem + 32'd1) : div_rem;
      if (div_zero_q) begin
         quo_s = DIVZ_LO;
         rem_s = div_a_raw_q;
      end
   end

   // HI/LO commit: moves in IDLE, results on retirement, nothing under flush
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!flush) begin
         case (state_q)
            ST_IDLE: begin
               if (op_valid && op[OP_MTHI]) hi_q <= src1;
               if (op_valid && op[OP_MTLO]) lo_q <= src1;
            end
            ST_MUL: begin
               hi_q <= prod[63:32];
               lo_q <= prod[31:0];
            end
            ST_DIV_DONE: begin
               hi_q <= rem_s;
               lo_q <= quo_s;
            end
            default: ;
         endcase
      end
   end

   assign rdata = (op_valid && op[OP_MFHI]) ? hi_q :
                  (op_valid && op[OP_MFLO]) ? lo_q : '0;
   assign busy  = (state_q != ST_IDLE);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
